// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract unit: a wide operand pair is pushed through one 4-bit
// slice, least significant nibble first, with valid/ready handshakes on both sides.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf,
    output logic                   zero
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  a_q, b_q;
    logic          sub_q;
    logic          carry;
    logic [IW-1:0] idx;

    logic          accept, step, last;
    logic [IW+1:0] shamt;
    logic [3:0]    a_nib, b_nib;
    logic [4:0]    sum5;
    logic [W-1:0]  result_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The active slice: B is inverted on subtract, the seeded carry supplies the +1.
    always_comb begin
        shamt       = {idx, 2'b00};
        a_nib       = 4'(a_q >> shamt);
        b_nib       = 4'(b_q >> shamt) ^ {4{sub_q}};
        sum5        = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
        result_next = (result & ~(W'(4'hF) << shamt)) | (W'(sum5[3:0]) << shamt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                sub_q <= sub;
                carry <= sub;
                idx   <= '0;
            end
            if (step) begin
                result <= result_next;
                carry  <= sum5[4];
                idx    <= idx + IW'(1);
            end
            // Flags see the complete result, including the nibble written this cycle.
            if (last) begin
                cout <= sub_q ^ sum5[4];
                ovf  <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) & (result_next[W-1] != a_q[W-1]);
                zero <= (result_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: directed cases, handshake
// corner cases and randomized operations against an arithmetic reference model.
module tb_nibble_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout, ovf, zero;

    int checks   = 0;
    int failures = 0;

    nibble_serial_addsub #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned/signed integer arithmetic on the whole words.
    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rsub,
                             output logic [W+2:0] exp_out);
        longint ua, ub, sa, sb, sr;
        logic [W-1:0] res;
        logic rc, rv;
        ua = longint'(ra);
        ub = longint'(rb);
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        if (rsub) begin
            res = W'(ua - ub);
            rc  = (ua < ub);
            sr  = sa - sb;
        end else begin
            res = W'(ua + ub);
            rc  = ((ua + ub) >= (64'sd1 <<< W));
            sr  = sa + sb;
        end
        rv = (sr > ((64'sd1 <<< (W - 1)) - 1)) || (sr < -(64'sd1 <<< (W - 1)));
        exp_out = {res, rc, rv, (res == '0)};
    endtask

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
        @(negedge clk);
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, result, cout, ovf, zero} !== {2'b10, {W{1'b0}}, 3'b000}) begin
            failures++;
            $display("[TB] FAIL reset_values got rdy=%b vld=%b res=%h c=%b v=%b z=%b want rdy=1 vld=0 res=0 flags=000",
                     in_ready, out_valid, result, cout, ovf, zero);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [W-1:0] ta [2] = '{16'h1234, 16'hFFFF};
        logic [W-1:0] tb [2] = '{16'h0FFF, 16'h0001};
        logic [W+2:0] te [2] = '{{16'h2233, 3'b000}, {16'h0000, 3'b101}};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], tb[i], 1'b0);
            wait_done(lat);
            checks++;
            if (lat !== N) begin
                failures++;
                $display("[TB] FAIL add_latency[%0d] got %0d want %0d", i, lat, N);
            end
            checks++;
            if ({result, cout, ovf, zero} !== te[i]) begin
                failures++;
                $display("[TB] FAIL add_result[%0d] got %h/%b%b%b want %h/%b", i, result, cout, ovf, zero,
                         te[i][W+2:3], te[i][2:0]);
            end
            finish_op();
        end
    endtask

    task automatic test_sub_borrow();
        logic [W-1:0] ta [2] = '{16'h0005, 16'h0007};
        logic [W-1:0] tb [2] = '{16'h0007, 16'h0005};
        logic [W+2:0] te [2] = '{{16'hFFFE, 3'b100}, {16'h0002, 3'b000}};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], tb[i], 1'b1);
            wait_done(lat);
            checks++;
            if ({result, cout, ovf, zero} !== te[i] || lat !== N) begin
                failures++;
                $display("[TB] FAIL sub_borrow[%0d] got %h/%b%b%b lat=%0d want %h/%b lat=%0d", i, result,
                         cout, ovf, zero, lat, te[i][W+2:3], te[i][2:0], N);
            end
            finish_op();
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] ta [2] = '{16'h7FFF, 16'h8000};
        logic         ts [2] = '{1'b0, 1'b1};
        logic [W+2:0] te [2] = '{{16'h8000, 3'b010}, {16'h7FFF, 3'b010}};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(ta[i], 16'h0001, ts[i]);
            wait_done(lat);
            checks++;
            if ({result, cout, ovf, zero} !== te[i]) begin
                failures++;
                $display("[TB] FAIL overflow[%0d] got %h/%b%b%b want %h/%b", i, result, cout, ovf, zero,
                         te[i][W+2:3], te[i][2:0]);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [W+2:0] exp_out;
        int lat;
        ref_model(16'h1234, 16'h4321, 1'b0, exp_out);
        start_op(16'h1234, 16'h4321, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (lat + 3 !== N) begin
            failures++;
            $display("[TB] FAIL bp_latency got %0d want %0d", lat + 3, N);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, result, cout, ovf, zero} !== {2'b10, exp_out}) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d] got vld=%b rdy=%b %h/%b%b%b want vld=1 rdy=0 %h/%b", i,
                         out_valid, in_ready, result, cout, ovf, zero, exp_out[W+2:3], exp_out[2:0]);
            end
        end
        finish_op();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit saw_valid = 0;
        start_op(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, result, cout, ovf, zero} !== {2'b10, {W{1'b0}}, 3'b000}) begin
            failures++;
            $display("[TB] FAIL midrun_reset got rdy=%b vld=%b res=%h c=%b v=%b z=%b want rdy=1 vld=0 res=0 flags=000",
                     in_ready, out_valid, result, cout, ovf, zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_no_valid got out_valid pulse=%b want 0", saw_valid);
        end
        start_op(16'h0001, 16'h0001, 1'b0);
        wait_done(lat);
        checks++;
        if (result !== 16'h0002 || lat !== N) begin
            failures++;
            $display("[TB] FAIL midrun_recover got %h lat=%0d want 0002 lat=%0d", result, lat, N);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [W+2:0] exp_out;
        logic [W-1:0] ra, rb;
        logic rs;
        int lat;
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = (i % 5 == 0) ? ra : W'($urandom);
            rs = 1'($urandom);
            ref_model(ra, rb, rs, exp_out);
            start_op(ra, rb, rs);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            checks++;
            if ({result, cout, ovf, zero} !== exp_out || lat !== N) begin
                failures++;
                $display("[TB] FAIL random[%0d] %h%s%h got %h/%b%b%b lat=%0d want %h/%b", i, ra,
                         rs ? "-" : "+", rb, result, cout, ovf, zero, lat, exp_out[W+2:3], exp_out[2:0]);
            end
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] exp_out;
        int accepts = 0;
        int dones = 0;
        ref_model(16'hC3A5, 16'h5A3C, 1'b1, exp_out);
        @(negedge clk);
        a = 16'hC3A5; b = 16'h5A3C; sub = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3 * (N + 2); k++) begin
            @(negedge clk);
            if (in_ready) accepts++;
            if (out_valid) begin
                dones++;
                checks++;
                if ({result, cout, ovf, zero} !== exp_out) begin
                    failures++;
                    $display("[TB] FAIL b2b_result got %h/%b%b%b want %h/%b", result, cout, ovf, zero,
                             exp_out[W+2:3], exp_out[2:0]);
                end
            end
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (accepts !== 3 || dones !== 3) begin
            failures++;
            $display("[TB] FAIL b2b_throughput got accepts=%0d dones=%0d want 3 and 3", accepts, dones);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_borrow();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
